// File: rtl/psum_accum_packer_pkg.sv
// Shared definitions for the partial-sum accumulator / packer.
// Optional feature macro: PSUM_SAT_EN (saturating accumulate instead of wrap).
package psum_accum_packer_pkg;

  localparam int B_PIXEL     = 16;
  localparam int DATA_WIDTH  = 64;
  localparam int N_LANE      = DATA_WIDTH / B_PIXEL;
  localparam int B_ADDR      = 9;
  localparam int B_NPASS     = 8;
  localparam int FIFO_DEPTH  = 4;

  localparam int OUT_LEN_LSB = 0;
  localparam int NPASS_LSB   = B_ADDR + 1;
  localparam int CFG_W       = B_ADDR + 1 + B_NPASS;

  localparam int LANE_W      = $clog2(N_LANE);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } state_t;

  // Signed accumulate of two pixels: clamps on overflow when PSUM_SAT_EN is set,
  // otherwise wraps modulo 2^B_PIXEL.
  function automatic logic [B_PIXEL-1:0] psum_add(input logic [B_PIXEL-1:0] a,
                                                  input logic [B_PIXEL-1:0] b);
`ifdef PSUM_SAT_EN
    logic [B_PIXEL:0] sum;
    sum = {a[B_PIXEL-1], a} + {b[B_PIXEL-1], b};
    if (sum[B_PIXEL] != sum[B_PIXEL-1])
      psum_add = sum[B_PIXEL] ? {1'b1, {(B_PIXEL-1){1'b0}}} : {1'b0, {(B_PIXEL-1){1'b1}}};
    else
      psum_add = sum[B_PIXEL-1:0];
`else
    psum_add = a + b;
`endif
  endfunction

endpackage

// File: rtl/psum_accum_packer_if.sv
// Partial-sum input stream and packed-word output stream of the packer.
// The slave modport is the packer's view, the master modport the surrounding logic.
interface psum_accum_packer_if;
  import psum_accum_packer_pkg::*;

  logic                  psum_valid;
  logic [B_PIXEL-1:0]    psum_i;
  logic                  psum_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output psum_valid, psum_i, m_ready,
    input  psum_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  psum_valid, psum_i, m_ready,
    output psum_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/psum_accum_packer_sync_fifo.sv
// Small synchronous FIFO holding packed output words (with their last flag).
// The head entry is presented combinationally; an empty FIFO presents zero.
module psum_accum_packer_sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psum_accum_packer.sv
// Accumulates a 16-bit partial-sum stream per output pixel across channel passes
// and, on the final pass, packs 4 pixels per 64-bit word toward the DDR writer.
// Optional feature macro: PSUM_SAT_EN (saturating add; default build wraps).
module psum_accum_packer
  import psum_accum_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] cfg,
  input  logic             cfg_we,
  psum_accum_packer_if.slave io,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);

  state_t state, state_next;

  logic [B_ADDR:0]       cfg_len;
  logic [B_NPASS-1:0]    cfg_npass;
  logic [B_ADDR:0]       out_len_r;
  logic [B_NPASS-1:0]    last_pass_r;
  logic [B_ADDR:0]       pix_cnt;
  logic [B_NPASS-1:0]    pass_cnt;
  logic                  start, accept, ready, pix_last, final_pass;

  logic                  s1_valid, s1_first, s1_final, s1_last;
  logic [B_PIXEL-1:0]    s1_data, ram_q, acc;
  logic [B_ADDR-1:0]     s1_addr, rd_addr;
  logic                  ram_we;
  logic [B_PIXEL-1:0]    ram [0:(1<<B_ADDR)-1];

  logic [N_LANE-1:0][B_PIXEL-1:0] lanes;
  logic [LANE_W-1:0]     lane_idx;

  logic                  push_full, push_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_din, fifo_dout;
  logic [CNT_W-1:0]      fifo_count;

  assign cfg_len    = cfg[OUT_LEN_LSB +: B_ADDR + 1];
  assign cfg_npass  = cfg[NPASS_LSB +: B_NPASS];
  assign start      = (state == IDLE) && cfg_we && (cfg_len != '0);
  assign pix_last   = (pix_cnt == out_len_r - (B_ADDR + 1)'(1));
  assign final_pass = (pass_cnt == last_pass_r);
  assign ready      = (state == ACCUM) && (!final_pass || (fifo_count <= READY_MAX));
  assign accept     = io.psum_valid && ready;
  assign rd_addr    = pix_cnt[B_ADDR-1:0];

  assign acc        = s1_first ? s1_data : psum_add(ram_q, s1_data);
  assign ram_we     = s1_valid && !s1_final;

  assign push_full  = s1_valid && s1_final && (lane_idx == LANE_W'(N_LANE - 1));
  assign push_flush = (state == FLUSH) && !s1_valid && (lane_idx != '0) && !fifo_full;
  assign fifo_push  = push_full || push_flush;
  assign fifo_din   = push_full ? {s1_last, acc, lanes[N_LANE-2:0]} : {1'b1, lanes};
  assign fifo_pop   = io.m_ready && !fifo_empty;

  assign io.psum_ready = ready;
  assign io.m_valid    = !fifo_empty;
  assign io.m_data     = fifo_dout[DATA_WIDTH-1:0];
  assign io.m_last     = fifo_dout[DATA_WIDTH];

  // Job configuration latch and pixel/pass counters, advanced only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_len_r   <= '0;
      last_pass_r <= '0;
      pix_cnt     <= '0;
      pass_cnt    <= '0;
    end else if (start) begin
      out_len_r   <= cfg_len;
      last_pass_r <= (cfg_npass == '0) ? '0 : cfg_npass - 1'b1;
      pix_cnt     <= '0;
      pass_cnt    <= '0;
    end else if (accept) begin
      if (pix_last) begin
        pix_cnt <= '0;
        if (!final_pass) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Stage-1 register: carries the accepted beat to the add/write-back cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
      s1_first <= 1'b0;
      s1_final <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data  <= io.psum_i;
        s1_addr  <= rd_addr;
        s1_first <= (pass_cnt == '0);
        s1_final <= final_pass;
        s1_last  <= final_pass && pix_last;
      end
    end
  end

  // Accumulator RAM; a read hitting the address being written this cycle takes
  // the fresh sum so back-to-back passes over a single pixel stay correct.
  always_ff @(posedge clk) begin
    if (ram_we) ram[s1_addr] <= acc;
    if (accept) ram_q <= (ram_we && (s1_addr == rd_addr)) ? acc : ram[rd_addr];
  end

  // Lane register: fills with final-pass sums, clears after each pushed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes    <= '0;
      lane_idx <= '0;
    end else if (push_full || push_flush) begin
      lanes    <= '0;
      lane_idx <= '0;
    end else if (s1_valid && s1_final) begin
      lanes[lane_idx] <= acc;
      lane_idx        <= lane_idx + 1'b1;
    end
  end

  psum_accum_packer_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs for the job sequencer.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (accept && final_pass && pix_last) state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (fifo_pop && fifo_dout[DATA_WIDTH]) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_accum_packer.sv
// Directed self-checking bench for psum_accum_packer.
// Build with PSUM_SAT_EN defined to check the saturating variant.
module tb_psum_accum_packer;
  import psum_accum_packer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [CFG_W-1:0] cfg;
  logic             cfg_we;
  logic             busy;
  logic             done;

  psum_accum_packer_if bus ();

  psum_accum_packer dut (
    .clk    (clk),
    .rst    (rst),
    .cfg    (cfg),
    .cfg_we (cfg_we),
    .io     (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_cyc = -1;
  int done_cyc = -1;
  logic [63:0] got_data[$];
  logic        got_last[$];
  logic [15:0] stim[$];
  logic [63:0] exp_words[4];
  logic [63:0] sat_word;

  // Output monitor: records every word handshake and every done pulse.
  always @(negedge clk) begin
    cyc++;
    if (bus.m_valid && bus.m_ready) begin
      got_data.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
      if (bus.m_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startJob(input int len, input int np);
    logic [B_ADDR:0]    l;
    logic [B_NPASS-1:0] n;
    l = len[B_ADDR:0];
    n = np[B_NPASS-1:0];
    got_data.delete();
    got_last.delete();
    cfg    = {n, l};
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus();
    int w;
    foreach (stim[i]) begin
      bus.psum_valid = 1'b1;
      bus.psum_i     = stim[i];
      w = 0;
      while (!bus.psum_ready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 100) begin
        checkOutput("psum_ready_timeout", {63'd0, bus.psum_ready}, 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    bus.psum_valid = 1'b0;
  endtask

  task automatic waitDone(input int exp_cnt);
    int w;
    w = 0;
    while (done_cnt < exp_cnt && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_count", 64'(done_cnt), 64'(exp_cnt));
  endtask

  task automatic checkWords(input string tag, input int n);
    checkOutput({tag, "_nwords"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_data.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_words[i]);
        checkOutput($sformatf("%s_last%0d", tag, i), {63'd0, got_last[i]}, {63'd0, (i == n - 1)});
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_psum_ready"}, {63'd0, bus.psum_ready}, 64'd0);
    checkOutput({tag, "_m_valid"},    {63'd0, bus.m_valid},    64'd0);
    checkOutput({tag, "_m_data"},     bus.m_data,              64'd0);
    checkOutput({tag, "_m_last"},     {63'd0, bus.m_last},     64'd0);
    checkOutput({tag, "_busy"},       {63'd0, busy},           64'd0);
    checkOutput({tag, "_done"},       {63'd0, done},           64'd0);
  endtask

  initial begin
    int acc_n;
    logic ready_now;

    rst = 1'b1;
    cfg = '0;
    cfg_we = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum_i = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] job 1: out_len=8 n_pass=1 ramp");
    startJob(8, 1);
    checkOutput("t1_busy", {63'd0, busy}, 64'd1);
    stim.delete();
    for (int i = 1; i <= 8; i++) stim.push_back(16'(i));
    applyStimulus();
    waitDone(1);
    exp_words[0] = 64'h0004_0003_0002_0001;
    exp_words[1] = 64'h0008_0007_0006_0005;
    checkWords("t1", 2);
    checkOutput("t1_done_timing", 64'(done_cyc), 64'(last_cyc + 1));
    checkOutput("t1_busy_after", {63'd0, busy}, 64'd0);

    $display("[TB] zero-length cfg is ignored");
    cfg = {8'd1, 10'd0};
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checkOutput("zlen_busy", {63'd0, busy}, 64'd0);
    checkOutput("zlen_psum_ready", {63'd0, bus.psum_ready}, 64'd0);

    $display("[TB] job 2: out_len=4 n_pass=3 constant");
    startJob(4, 3);
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(16'h0010);
    applyStimulus();
    waitDone(2);
    exp_words[0] = 64'h0030_0030_0030_0030;
    checkWords("t2", 1);

    $display("[TB] job 3: out_len=1 n_pass=4 forwarding");
    startJob(1, 4);
    stim.delete();
    for (int i = 5; i <= 8; i++) stim.push_back(16'(i));
    applyStimulus();
    waitDone(3);
    exp_words[0] = 64'h0000_0000_0000_001A;
    checkWords("t3", 1);

    $display("[TB] n_pass=0 behaves as one pass");
    startJob(4, 0);
    stim.delete();
    for (int i = 1; i <= 4; i++) stim.push_back(16'(i));
    applyStimulus();
    waitDone(4);
    exp_words[0] = 64'h0004_0003_0002_0001;
    checkWords("np0", 1);

    $display("[TB] job 4: out_len=6 with output stalled");
    bus.m_ready = 1'b0;
    startJob(6, 1);
    stim.delete();
    for (int i = 1; i <= 6; i++) stim.push_back(16'(i));
    applyStimulus();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_m_valid", {63'd0, bus.m_valid}, 64'd1);
    checkOutput("t4_hold_data", bus.m_data, 64'h0004_0003_0002_0001);
    checkOutput("t4_hold_last", {63'd0, bus.m_last}, 64'd0);
    checkOutput("t4_busy", {63'd0, busy}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_hold_data2", bus.m_data, 64'h0004_0003_0002_0001);
    bus.m_ready = 1'b1;
    waitDone(5);
    exp_words[0] = 64'h0004_0003_0002_0001;
    exp_words[1] = 64'h0000_0000_0006_0005;
    checkWords("t4", 2);

    $display("[TB] job 4b: out_len=16 backpressure throttles input");
    bus.m_ready = 1'b0;
    startJob(16, 1);
    acc_n = 0;
    for (int i = 0; i < 40; i++) begin
      bus.psum_valid = (acc_n < 16);
      bus.psum_i = 16'(acc_n + 1);
      ready_now = bus.psum_ready;
      @(posedge clk); #1;
      if (bus.psum_valid && ready_now) acc_n++;
    end
    bus.psum_valid = 1'b0;
    checkOutput("t4b_accepted", 64'(acc_n), 64'd13);
    checkOutput("t4b_psum_ready", {63'd0, bus.psum_ready}, 64'd0);
    bus.m_ready = 1'b1;
    stim.delete();
    for (int i = acc_n + 1; i <= 16; i++) stim.push_back(16'(i));
    applyStimulus();
    waitDone(6);
    exp_words[0] = 64'h0004_0003_0002_0001;
    exp_words[1] = 64'h0008_0007_0006_0005;
    exp_words[2] = 64'h000C_000B_000A_0009;
    exp_words[3] = 64'h0010_000F_000E_000D;
    checkWords("t4b", 4);

    $display("[TB] job 5: overflow on accumulate");
    startJob(4, 2);
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(16'h7FFF);
    for (int i = 0; i < 4; i++) stim.push_back(16'h0001);
    applyStimulus();
    waitDone(7);
`ifdef PSUM_SAT_EN
    sat_word = 64'h7FFF_7FFF_7FFF_7FFF;
`else
    sat_word = 64'h8000_8000_8000_8000;
`endif
    exp_words[0] = sat_word;
    checkWords("t5", 1);

    $display("[TB] job 6: reset mid-job then fresh job");
    startJob(4, 2);
    stim.delete();
    for (int i = 1; i <= 3; i++) stim.push_back(16'(i));
    applyStimulus();
    rst = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("t6_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_busy_after", {63'd0, busy}, 64'd0);
    startJob(4, 1);
    stim.delete();
    stim.push_back(16'd10);
    stim.push_back(16'd20);
    stim.push_back(16'd30);
    stim.push_back(16'd40);
    applyStimulus();
    waitDone(8);
    exp_words[0] = 64'h0028_001E_0014_000A;
    checkWords("t6", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
